irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending bits, mask, fixed priority
// (source 0 highest) and an IDLE/REQ/SVC handshake with the CPU.
module irq_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            bus_clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic [1:0]      addr,
    input  logic            write,
    input  logic [15:0]     bus_in,
    output logic [15:0]     bus_out,
    output logic            cpu_irq,
    input  logic            cpu_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2
    } state_t;

    localparam logic [1:0] A_PENDING = 2'd0;
    localparam logic [1:0] A_MASK    = 2'd1;
    localparam logic [1:0] A_VECTOR  = 2'd2;
    localparam logic [1:0] A_CTRL    = 2'd3;

    state_t          r_state;
    logic [NSRC-1:0] r_irq_prev;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic            r_en;
    logic [2:0]      r_in_service;

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_active;
    logic            w_valid;
    logic [2:0]      w_vector;
    logic            w_wr_pend;
    logic            w_wr_mask;
    logic            w_wr_ctrl;
    logic            w_eoi;
    logic            w_take_ack;
    logic [NSRC-1:0] w_pend_clr;
    logic [NSRC-1:0] w_pend_next;

    assign w_rise   = irq_in & ~r_irq_prev;
    assign w_active = r_pending & r_mask;
    assign w_valid  = |w_active;

    // Scan downward so the lowest active index is the last one assigned.
    always_comb begin
        w_vector = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_vector = 3'(i);
            end
        end
    end

    assign w_wr_pend  = write && (addr == A_PENDING);
    assign w_wr_mask  = write && (addr == A_MASK);
    assign w_wr_ctrl  = write && (addr == A_CTRL);
    assign w_eoi      = w_wr_ctrl && bus_in[8];
    assign w_take_ack = (r_state == S_REQ) && cpu_ack && r_en && w_valid;

    // A rising edge in the same cycle as any clear leaves the bit set.
    assign w_pend_clr  = (w_wr_pend ? bus_in[NSRC-1:0] : '0)
                       | (w_take_ack ? (NSRC'(1) << w_vector) : '0);
    assign w_pend_next = (r_pending & ~w_pend_clr) | w_rise;

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_irq_prev   <= '1;
            r_pending    <= '0;
            r_mask       <= '0;
            r_en         <= 1'b0;
            r_in_service <= 3'd0;
        end else begin
            r_irq_prev <= irq_in;
            r_pending  <= w_pend_next;
            if (w_wr_mask) begin
                r_mask <= bus_in[NSRC-1:0];
            end
            if (w_wr_ctrl) begin
                r_en <= bus_in[0];
            end
            case (r_state)
                S_IDLE: begin
                    if (r_en && w_valid) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!r_en || !w_valid) begin
                        r_state <= S_IDLE;
                    end else if (cpu_ack) begin
                        r_in_service <= w_vector;
                        r_state      <= S_SVC;
                    end
                end
                S_SVC: begin
                    if (w_eoi) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu_irq = (r_state == S_REQ);

    always_comb begin
        bus_out = 16'h0000;
        case (addr)
            A_PENDING: bus_out = {8'b0, r_pending};
            A_MASK:    bus_out = {8'b0, r_mask};
            A_VECTOR:  bus_out = {w_valid, 8'b0, r_in_service, 1'b0, w_vector};
            A_CTRL:    bus_out = {6'b0, r_state, 7'b0, r_en};
            default:   bus_out = 16'h0000;
        endcase
    end

endmodule
